switch_fabric_core: RTL

// - Parametrised N-port packet switch core; next generation of the single-port switch interface.
// - Inputs carry {addr, data} on a valid/ready handshake.
// - Each packet is routed by matching its addr against a programmable per-port address table.
// - Packets are buffered in per-output FIFOs; contention on each output is resolved by round-robin.
// - Sits between the testcase-side interface drivers and the per-port monitors.

---
 rtl/switch_fabric_core.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/switch_fabric_core.sv
// N-port packet switch core: per-input address-table lookup, per-output round-robin
// arbitration and a DEPTH-entry FIFO in front of every output port.
module switch_fabric_core #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 48,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(N_PORTS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic                       cfg_en,
  input  logic [N_PORTS-1:0]         src_valid,
  output logic [N_PORTS-1:0]         src_ready,
  input  logic [N_PORTS*ADDR_W-1:0]  src_addr,
  input  logic [N_PORTS*DATA_W-1:0]  src_data,
  output logic [N_PORTS-1:0]         dst_valid,
  input  logic [N_PORTS-1:0]         dst_ready,
  output logic [N_PORTS*ADDR_W-1:0]  dst_addr,
  output logic [N_PORTS*DATA_W-1:0]  dst_data,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PW    = $clog2(N_PORTS);
  localparam int FW    = $clog2(DEPTH);
  localparam int PKT_W = ADDR_W + DATA_W;
  localparam int DW    = PW + 1;
  localparam int SW    = CNT_W + DW;

  typedef logic [PKT_W-1:0] pkt_t;

  logic [N_PORTS-1:0] tbl_valid;
  logic [ADDR_W-1:0]  tbl_addr [N_PORTS];

  logic [N_PORTS-1:0] hit;
  logic [PW-1:0]      dest     [N_PORTS];

  logic [FW-1:0]      wr_ptr   [N_PORTS];
  logic [FW-1:0]      rd_ptr   [N_PORTS];
  logic [FW:0]        fill     [N_PORTS];
  pkt_t               mem      [N_PORTS][DEPTH];
  logic [PW-1:0]      rr_ptr   [N_PORTS];

  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] pop;
  logic [N_PORTS-1:0] push;
  logic [PW-1:0]      push_src [N_PORTS];
  pkt_t               push_pkt [N_PORTS];

  logic [N_PORTS-1:0] drop_req;
  logic [DW-1:0]      n_drop;
  logic [SW-1:0]      drop_sum;

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int j = 0; j < N_PORTS; j++) tbl_addr[j] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < N_PORTS)) begin
      tbl_valid[cfg_idx] <= cfg_en;
      tbl_addr[cfg_idx]  <= cfg_addr;
    end
  end

  // NOTE: every signal driven here gets a default before any condition, so no
  // latch can be inferred.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      hit[i]  = 1'b0;
      dest[i] = '0;
      // Scanning downwards lets the lowest matching entry win.
      for (int j = N_PORTS - 1; j >= 0; j--) begin
        if (tbl_valid[j] && (tbl_addr[j] == src_addr[i*ADDR_W +: ADDR_W])) begin
          hit[i]  = 1'b1;
          dest[i] = PW'(j);
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      full[o] = (fill[o] == (FW+1)'(DEPTH));
      pop[o]  = (fill[o] != '0) && dst_ready[o];
    end
  end

  // Per output: the requester closest to rr_ptr (walking upwards, wrapping) wins.
  always_comb begin
    src_ready = ~hit;
    for (int o = 0; o < N_PORTS; o++) begin
      int                 best_d;
      logic [N_PORTS-1:0] gnt_o;
      best_d      = N_PORTS;
      gnt_o       = '0;
      push[o]     = 1'b0;
      push_src[o] = '0;
      push_pkt[o] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        int d;
        d = i - int'(rr_ptr[o]);
        if (d < 0) d = d + N_PORTS;
        if (!full[o] && src_valid[i] && hit[i] && (dest[i] == PW'(o)) && (d < best_d)) begin
          best_d      = d;
          gnt_o       = '0;
          gnt_o[i]    = 1'b1;
          push[o]     = 1'b1;
          push_src[o] = PW'(i);
          push_pkt[o] = {src_addr[i*ADDR_W +: ADDR_W], src_data[i*DATA_W +: DATA_W]};
        end
      end
      src_ready = src_ready | gnt_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_PORTS; o++) begin
        wr_ptr[o] <= '0;
        rd_ptr[o] <= '0;
        fill[o]   <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (push[o]) begin
          wr_ptr[o] <= wr_ptr[o] + FW'(1);
          rr_ptr[o] <= (push_src[o] == PW'(N_PORTS - 1)) ? '0 : push_src[o] + PW'(1);
        end
        if (pop[o]) rd_ptr[o] <= rd_ptr[o] + FW'(1);
        case ({push[o], pop[o]})
          2'b10:   fill[o] <= fill[o] + (FW+1)'(1);
          2'b01:   fill[o] <= fill[o] - (FW+1)'(1);
          default: fill[o] <= fill[o];
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; the fill count gates dst_* so stale entries
  // can never be observed after a reset.
  always_ff @(posedge clk) begin
    for (int o = 0; o < N_PORTS; o++) begin
      if (push[o]) mem[o][wr_ptr[o]] <= push_pkt[o];
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_out
    pkt_t head;
    assign dst_valid[g]                 = (fill[g] != '0);
    assign head                         = dst_valid[g] ? mem[g][rd_ptr[g]] : '0;
    assign dst_addr[g*ADDR_W +: ADDR_W] = head[PKT_W-1 -: ADDR_W];
    assign dst_data[g*DATA_W +: DATA_W] = head[DATA_W-1:0];
  end

  // Unmatched packets are always accepted and counted; the counter saturates.
  always_comb begin
    drop_req = src_valid & ~hit;
    n_drop   = '0;
    for (int i = 0; i < N_PORTS; i++) n_drop = n_drop + DW'(drop_req[i]);
    drop_sum = SW'(drop_cnt) + SW'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_sum[SW-1:CNT_W] != '0) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

endmodule
